// File: rtl/sr04_multi_ranger_pkg.sv
// Shared definitions for the multi-channel HC-SR04 ranger: FSM states,
// microsecond divider and distance scaling constants.
package sr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_DONE,
        ST_FAIL,
        ST_GAP
    } state_t;

    // Default system clock and the matching microsecond divider
    localparam int unsigned DEF_CLK_HZ  = 100_000_000;
    localparam int unsigned US_DIV      = DEF_CLK_HZ / 1_000_000;

    // cm = (echo_us * SCALE) >> SCALE_SHIFT; SCALE must fit in SCALE_W bits
    localparam int unsigned DEF_SCALE   = 1130;
    localparam int unsigned SCALE_SHIFT = 16;
    localparam int unsigned SCALE_W     = 11;

    function automatic int unsigned us_div(input int unsigned clk_hz);
        return clk_hz / 1_000_000;
    endfunction

    // Index width with a floor of one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sr04_multi_ranger_if.sv
// Host/sensor-facing signal bundle of the multi-channel ranger.
interface sr04_multi_ranger_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DIST_W = 12
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     start;
    logic                     auto_en;
    logic [N_CH-1:0]          echo;
    logic [N_CH-1:0]          trigger;
    logic [N_CH*DIST_W-1:0]   distance;
    logic                     valid;
    logic [CH_W-1:0]          valid_ch;
    logic [N_CH-1:0]          err;
    logic                     busy;

    // Host side: issues start/auto and presents the sensor echoes
    modport master (
        output start, auto_en, echo,
        input  trigger, distance, valid, valid_ch, err, busy
    );

    // Ranger side
    modport slave (
        input  start, auto_en, echo,
        output trigger, distance, valid, valid_ch, err, busy
    );

endinterface

// File: rtl/sr04_multi_ranger_us_tick_gen.sv
// One-clock tick every DIV clocks; clr restarts the period so a trigger
// pulse starts aligned with the tick grid.
module us_tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // Divider counter with registered tick output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/sr04_multi_ranger.sv
// Round-robin controller for N_CH HC-SR04 sensors: one channel triggered at
// a time, echo timed in microseconds, scaled to cm, timeout flagged per channel.
module sr04_multi_ranger
    import sr04_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned N_CH       = 2,
    parameter int unsigned DIST_W     = 12,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 25_000,
    parameter int unsigned GAP_US     = 60_000,
    parameter int unsigned SCALE      = 1130
) (
    input  logic                 clk,
    input  logic                 reset,
    sr04_multi_ranger_if.slave   bus
);
    localparam int unsigned DIV    = us_div(CLK_HZ);
    localparam int unsigned CH_W   = idx_width(N_CH);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_US + 1);
    localparam int unsigned T_MAX1 = (TIMEOUT_US > GAP_US) ? TIMEOUT_US : GAP_US;
    localparam int unsigned T_MAX  = (T_MAX1 > TRIG_US) ? T_MAX1 : TRIG_US;
    localparam int unsigned TW     = $clog2(T_MAX + 1);
    localparam int unsigned PW     = CNT_W + SCALE_W;
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    state_t                 state;
    logic [CH_W-1:0]        ch;
    logic [CH_W-1:0]        ch_next;
    logic [CNT_W-1:0]       cnt;
    logic [TW-1:0]          timer;
    logic [N_CH-1:0]        echo_s1, echo_s2, echo_s3;
    logic                   echo_cur, echo_rise;
    logic                   tick, launch, gap_end;
    logic [PW-1:0]          prod, scaled;
    logic [DIST_W-1:0]      dist_val;

    logic [N_CH-1:0]        trigger;
    logic [N_CH*DIST_W-1:0] distance;
    logic                   valid;
    logic [CH_W-1:0]        valid_ch;
    logic [N_CH-1:0]        err;
    logic                   busy;

    assign bus.trigger  = trigger;
    assign bus.distance = distance;
    assign bus.valid    = valid;
    assign bus.valid_ch = valid_ch;
    assign bus.err      = err;
    assign bus.busy     = busy;

    us_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (launch),
        .tick  (tick)
    );

    // Two-stage synchronizer plus one history stage for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_s3 <= '0;
        end else begin
            echo_s1 <= bus.echo;
            echo_s2 <= echo_s1;
            echo_s3 <= echo_s2;
        end
    end

    // Channel select, launch decision and clamped distance from the echo count
    always_comb begin
        echo_cur  = echo_s2[ch];
        echo_rise = echo_s2[ch] & ~echo_s3[ch];
        gap_end   = (state == ST_GAP) && tick && (timer == TW'(GAP_US - 1));
        launch    = 1'b0;
        if (state == ST_IDLE)
            launch = bus.start || bus.auto_en;
        else if (gap_end)
            launch = (ch != LAST_CH) || bus.auto_en;
        ch_next   = ((state == ST_GAP) && (ch != LAST_CH)) ? ch + 1'b1 : '0;
        prod      = PW'(cnt) * PW'(SCALE);
        scaled    = prod >> SCALE_SHIFT;
        dist_val  = (scaled > PW'(DIST_MAX)) ? DIST_MAX : DIST_W'(scaled);
    end

    // Sweep sequencer with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ch       <= '0;
            cnt      <= '0;
            timer    <= '0;
            trigger  <= '0;
            distance <= '0;
            valid    <= 1'b0;
            valid_ch <= '0;
            err      <= '0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        ch      <= '0;
                        busy    <= 1'b1;
                        timer   <= '0;
                        trigger <= N_CH'(1);
                        state   <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    if (tick) begin
                        if (timer == TW'(TRIG_US - 1)) begin
                            trigger <= '0;
                            timer   <= '0;
                            state   <= ST_WAIT_RISE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_WAIT_RISE: begin
                    if (echo_rise) begin
                        cnt   <= '0;
                        state <= ST_MEASURE;
                    end else if (tick) begin
                        if (timer == TW'(TIMEOUT_US - 1))
                            state <= ST_FAIL;
                        else
                            timer <= timer + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (!echo_cur) begin
                        state <= ST_DONE;
                    end else if (tick) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(TIMEOUT_US - 1))
                            state <= ST_FAIL;
                    end
                end
                ST_DONE: begin
                    for (int unsigned k = 0; k < N_CH; k++) begin
                        if (ch == CH_W'(k))
                            distance[k*DIST_W +: DIST_W] <= dist_val;
                    end
                    err[ch]  <= 1'b0;
                    valid    <= 1'b1;
                    valid_ch <= ch;
                    timer    <= '0;
                    state    <= ST_GAP;
                end
                ST_FAIL: begin
                    err[ch] <= 1'b1;
                    timer   <= '0;
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_end) begin
                        timer <= '0;
                        if (launch) begin
                            ch      <= ch_next;
                            trigger <= N_CH'(1) << ch_next;
                            state   <= ST_TRIG;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else if (tick) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr04_multi_ranger.sv
// Directed bench for sr04_multi_ranger: a 2-channel instance with a 2-clk
// microsecond and short timeout/gap, plus a 1-channel 8-bit instance for clamping.
module tb_sr04_multi_ranger;

    localparam int unsigned N_CH       = 2;
    localparam int unsigned DIST_W     = 12;
    localparam int unsigned DIV        = 2;
    localparam int unsigned TRIG_US    = 10;
    localparam int unsigned TIMEOUT_US = 2000;
    localparam int unsigned GAP_US     = 100;

    localparam int P_TRIG   = 0;
    localparam int P_VALID  = 1;
    localparam int P_BUSY   = 2;
    localparam int P_ERR    = 3;
    localparam int P_TRIG2  = 4;
    localparam int P_VALID2 = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   overlap_cnt = 0;
    int   valid_cnt = 0;

    always #5 clk = ~clk;

    sr04_multi_ranger_if #(.N_CH(N_CH), .DIST_W(DIST_W)) bus ();
    sr04_multi_ranger_if #(.N_CH(1), .DIST_W(8)) bus2 ();

    sr04_multi_ranger #(
        .CLK_HZ(2_000_000), .N_CH(N_CH), .DIST_W(DIST_W), .TRIG_US(TRIG_US),
        .TIMEOUT_US(TIMEOUT_US), .GAP_US(GAP_US), .SCALE(1130)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    sr04_multi_ranger #(
        .CLK_HZ(1_000_000), .N_CH(1), .DIST_W(8), .TRIG_US(10),
        .TIMEOUT_US(25_000), .GAP_US(100), .SCALE(1130)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    // Clock counter for spacing measurements
    always @(posedge clk) cyc++;

    // Watch for overlapping triggers and count valid strobes
    always @(negedge clk) begin
        if ($countones(bus.trigger) > 1) overlap_cnt++;
        if (bus.valid === 1'b1) valid_cnt++;
    end

    // Hard time limit
    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic probe(input int which, input int idx);
        case (which)
            P_TRIG:   return bus.trigger[idx];
            P_VALID:  return bus.valid;
            P_BUSY:   return bus.busy;
            P_ERR:    return bus.err[idx];
            P_TRIG2:  return bus2.trigger[0];
            P_VALID2: return bus2.valid;
            default:  return 1'bx;
        endcase
    endfunction

    task automatic wait_for(input int which, input int idx, input logic lvl,
                            input int budget, input string tag, output int n);
        n = 0;
        while (probe(which, idx) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (probe(which, idx) === lvl) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b within %0d clk", tag, probe(which, idx), lvl, budget);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Answer channel c with an echo of hi clocks and check the reported result
    task automatic service(input int c, input int hi, input int exp_d);
        int n;
        logic [DIST_W-1:0] f;
        wait_for(P_TRIG, c, 1'b1, 6000, "trig_rise", n);
        wait_for(P_TRIG, c, 1'b0, 100, "trig_fall", n);
        repeat (10) @(negedge clk);
        bus.echo[c] = 1'b1;
        repeat (hi) @(negedge clk);
        bus.echo[c] = 1'b0;
        wait_for(P_VALID, 0, 1'b1, 8, "valid_rise", n);
        f = bus.distance[c*DIST_W +: DIST_W];
        chk("valid_ch", bus.valid_ch, c);
        chk("dist_field", f, exp_d);
        chk("err_clear", bus.err[c], 0);
    endtask

    initial begin
        int n;
        int t0;
        int v0;
        reset = 1'b1;
        bus.start = 1'b0;  bus.auto_en = 1'b0;  bus.echo = '0;
        bus2.start = 1'b0; bus2.auto_en = 1'b0; bus2.echo = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_trigger", bus.trigger, 0);
        chk("rst_distance", bus.distance, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_valid_ch", bus.valid_ch, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_distance2", bus2.distance, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Sweep 1: 600us -> 10cm on ch0, 1170us -> 20cm on ch1
        pulse_start();
        t0 = cyc;
        chk("t1_busy", bus.busy, 1);
        chk("t1_trig0", bus.trigger, 2'b01);
        wait_for(P_TRIG, 0, 1'b0, 100, "t1_trig0_fall", n);
        chk_rng("t1_trig_width", n, TRIG_US*DIV - 1, TRIG_US*DIV + 1);
        repeat (10) @(negedge clk);
        bus.echo[0] = 1'b1;
        repeat (600*DIV) @(negedge clk);
        bus.echo[0] = 1'b0;
        wait_for(P_VALID, 0, 1'b1, 8, "t1_valid0", n);
        chk("t1_valid_ch0", bus.valid_ch, 0);
        chk("t1_dist0", bus.distance[DIST_W-1:0], 10);
        @(negedge clk);
        chk("t1_valid_pulse", bus.valid, 0);
        wait_for(P_TRIG, 1, 1'b1, 1000, "t1_trig1_rise", n);
        chk_rng("t1_trig_spacing", cyc - t0, GAP_US*DIV, 100_000);
        service(1, 1170*DIV, 20);
        wait_for(P_BUSY, 0, 1'b0, 1000, "t1_busy_fall", n);
        chk_rng("t1_busy_after_gap", n, GAP_US*DIV - 5, GAP_US*DIV + 10);
        chk("t1_distance", bus.distance, {12'd20, 12'd10});
        chk("t1_valid_count", valid_cnt, 2);

        // Sweep 2: ch1 silent -> timeout, field kept, no valid for ch1
        v0 = valid_cnt;
        pulse_start();
        service(0, 600*DIV, 10);
        wait_for(P_TRIG, 1, 1'b1, 1000, "t3_trig1_rise", n);
        wait_for(P_TRIG, 1, 1'b0, 100, "t3_trig1_fall", n);
        wait_for(P_ERR, 1, 1'b1, 5000, "t3_err1", n);
        chk_rng("t3_timeout_time", n, TIMEOUT_US*DIV - 5, TIMEOUT_US*DIV + 10);
        chk("t3_dist1_kept", bus.distance[2*DIST_W-1:DIST_W], 20);
        chk("t3_valid_count", valid_cnt - v0, 1);
        wait_for(P_BUSY, 0, 1'b0, 1000, "t3_busy_fall", n);
        chk("t3_err", bus.err, 2'b10);

        // Sweep 3: ch1 answers again -> err cleared
        pulse_start();
        service(0, 600*DIV, 10);
        service(1, 600*DIV, 10);
        chk("t3_err_cleared", bus.err, 0);
        wait_for(P_BUSY, 0, 1'b0, 1000, "t3b_busy_fall", n);

        // Sweep 4: ch0 echo stuck high -> measure timeout, sweep continues
        pulse_start();
        wait_for(P_TRIG, 0, 1'b0, 100, "t4_trig0_fall", n);
        bus.echo[0] = 1'b1;
        wait_for(P_ERR, 0, 1'b1, 5000, "t4_err0", n);
        chk_rng("t4_timeout_time", n, TIMEOUT_US*DIV - 5, TIMEOUT_US*DIV + 15);
        chk("t4_dist0_kept", bus.distance[DIST_W-1:0], 10);
        bus.echo[0] = 1'b0;
        service(1, 1170*DIV, 20);
        chk("t4_err", bus.err, 2'b01);
        wait_for(P_BUSY, 0, 1'b0, 1000, "t4_busy_fall", n);

        // Auto mode for three sweeps; stop and pulse start during the last one
        v0 = valid_cnt;
        bus.auto_en = 1'b1;
        for (int s = 0; s < 3; s++) begin
            service(0, 600*DIV, 10);
            if (s == 2) begin
                pulse_start();
                bus.auto_en = 1'b0;
            end
            service(1, 1170*DIV, 20);
        end
        chk("t6_err", bus.err, 0);
        wait_for(P_BUSY, 0, 1'b0, 1000, "t6_busy_fall", n);
        repeat (400) @(negedge clk);
        chk("t6_idle_busy", bus.busy, 0);
        chk("t6_idle_trigger", bus.trigger, 0);
        chk("t6_valid_count", valid_cnt - v0, 6);

        // 8-bit instance: 20000us echo -> raw 344, clamped to 255
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        wait_for(P_TRIG2, 0, 1'b0, 50, "t5_trig_fall", n);
        repeat (5) @(negedge clk);
        bus2.echo[0] = 1'b1;
        repeat (20_000) @(negedge clk);
        bus2.echo[0] = 1'b0;
        wait_for(P_VALID2, 0, 1'b1, 8, "t5_valid", n);
        chk("t5_clamp", bus2.distance, 255);
        chk("t5_err", bus2.err, 0);

        // Reset during MEASURE returns everything to reset values
        pulse_start();
        wait_for(P_TRIG, 0, 1'b0, 100, "t7_trig_fall", n);
        bus.echo[0] = 1'b1;
        repeat (100) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t7_trigger", bus.trigger, 0);
        chk("t7_distance", bus.distance, 0);
        chk("t7_valid", bus.valid, 0);
        chk("t7_valid_ch", bus.valid_ch, 0);
        chk("t7_err", bus.err, 0);
        chk("t7_busy", bus.busy, 0);
        bus.echo[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset during TRIG drops the trigger before the next clock edge
        pulse_start();
        chk("t7_trig_high", bus.trigger, 2'b01);
        #2 reset = 1'b1;
        #1;
        chk("t7_trig_async", bus.trigger, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("no_trigger_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
